spi2wb_bridge: RTL and testbench

- SPI mode-0 slave that acts as a Wishbone master: the opposite end of the wb2spi path.
- The wb2spi DUT initiates SPI frames; this block responds to them and converts each frame into one Wishbone single read or write.
- Used as the bench-side SPI responder and as a standalone register-access port.
- Wishbone side matches the wb2spi bus geometry: 2-bit address, 8-bit data.

---
 rtl/spi2wb_bridge_if.sv | 33 +++
 rtl/spi2wb_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_spi2wb_bridge.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi2wb_bridge_if.sv
// Pin bundle for the SPI-slave / Wishbone-master bridge.
// "master" is the bridge's view; "slave" is the SPI host plus Wishbone target.
interface spi2wb_bridge_if #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8
);
  logic                     sck_i;
  logic                     ss_n_i;
  logic                     mosi_i;
  logic                     miso_o;
  logic                     miso_oe_o;
  logic                     wb_cyc_o;
  logic                     wb_stb_o;
  logic                     wb_we_o;
  logic [WB_ADDR_WIDTH-1:0] wb_adr_o;
  logic [WB_DATA_WIDTH-1:0] wb_dat_o;
  logic [WB_DATA_WIDTH-1:0] wb_dat_i;
  logic                     wb_ack_i;
  logic                     busy_o;
  logic                     err_o;

  modport master (
    input  sck_i, ss_n_i, mosi_i, wb_dat_i, wb_ack_i,
    output miso_o, miso_oe_o, wb_cyc_o, wb_stb_o, wb_we_o,
           wb_adr_o, wb_dat_o, busy_o, err_o
  );

  modport slave (
    output sck_i, ss_n_i, mosi_i, wb_dat_i, wb_ack_i,
    input  miso_o, miso_oe_o, wb_cyc_o, wb_stb_o, wb_we_o,
           wb_adr_o, wb_dat_o, busy_o, err_o
  );
endinterface

// File: rtl/spi2wb_bridge.sv
// SPI mode-0 slave that turns each frame (command byte + data phase) into one
// Wishbone single read or write, with ack timeout and read-underrun reporting.
module spi2wb_bridge #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  spi2wb_bridge_if.master bus
);

  localparam int FRAME_BITS = 8 + WB_DATA_WIDTH;
  localparam int SH_W       = (WB_DATA_WIDTH > 8) ? WB_DATA_WIDTH : 8;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int TMO_W      = $clog2(ACK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(8);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(FRAME_BITS);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } state_t;

  // Input synchronisers; sck keeps a third stage for edge detection
  logic [2:0] sck_sync_q,  sck_sync_d;
  logic [1:0] ss_n_sync_q, ss_n_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  logic sck_rise;
  logic sck_fall;
  logic ss_active;
  logic mosi_s;

  // Frame-side state
  logic [CNT_W-1:0]         bit_cnt_q,   bit_cnt_d;
  logic [SH_W-2:0]          shift_in_q,  shift_in_d;
  logic [WB_DATA_WIDTH-1:0] shift_out_q, shift_out_d;
  logic                     cmd_rd_q,    cmd_rd_d;
  logic [WB_ADDR_WIDTH-1:0] cmd_adr_q,   cmd_adr_d;
  logic [WB_DATA_WIDTH-1:0] rd_data_q,   rd_data_d;
  logic                     rd_valid_q,  rd_valid_d;
  logic                     rd_wanted_q, rd_wanted_d;

  // Wishbone-side state
  state_t                   state_q,     state_d;
  logic [TMO_W-1:0]         tmo_q,       tmo_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q,       adr_d;
  logic [WB_DATA_WIDTH-1:0] dat_q,       dat_d;
  logic                     err_q,       err_d;

  // Combinational handshakes between the two halves
  logic [SH_W-1:0]          shift_next;
  logic                     req_rd;
  logic                     req_wr;
  logic [WB_ADDR_WIDTH-1:0] req_adr;
  logic [WB_DATA_WIDTH-1:0] req_dat;
  logic                     underrun;

  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], bus.sck_i};
    ss_n_sync_d = {ss_n_sync_q[0],  bus.ss_n_i};
    mosi_sync_d = {mosi_sync_q[0],  bus.mosi_i};
  end

  assign sck_rise  =  sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall  = ~sck_sync_q[1] &  sck_sync_q[2];
  assign ss_active = ~ss_n_sync_q[1];
  assign mosi_s    =  mosi_sync_q[1];

  // Frame decoder: bit counting, command/data capture and miso shifting
  always_comb begin
    shift_next  = {shift_in_q, mosi_s};
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    cmd_rd_d    = cmd_rd_q;
    cmd_adr_d   = cmd_adr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    rd_wanted_d = rd_wanted_q;
    req_rd      = 1'b0;
    req_wr      = 1'b0;
    req_adr     = cmd_adr_q;
    req_dat     = shift_next[WB_DATA_WIDTH-1:0];
    underrun    = 1'b0;

    if (state_q == ST_RD && bus.wb_ack_i && rd_wanted_q) begin
      rd_data_d  = bus.wb_dat_i;
      rd_valid_d = 1'b1;
    end

    if (!ss_active) begin
      bit_cnt_d   = '0;
      shift_in_d  = '0;
      shift_out_d = '0;
      cmd_rd_d    = 1'b0;
      rd_valid_d  = 1'b0;
      rd_wanted_d = 1'b0;
    end else begin
      if (sck_rise && bit_cnt_q != FRAME_END) begin
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        shift_in_d = shift_next[SH_W-2:0];
        if (bit_cnt_q == CMD_LAST) begin
          cmd_rd_d  = shift_next[7];
          cmd_adr_d = shift_next[WB_ADDR_WIDTH-1:0];
          req_rd    = shift_next[7];
          req_adr   = shift_next[WB_ADDR_WIDTH-1:0];
          if (shift_next[7] && state_q == ST_IDLE) begin
            rd_wanted_d = 1'b1;
            rd_valid_d  = 1'b0;
          end
        end
        if (bit_cnt_q == FRAME_LAST && !cmd_rd_q) begin
          req_wr = 1'b1;
        end
      end

      // Late read data is dropped: rd_wanted closes at the first data fall
      if (sck_fall && cmd_rd_q) begin
        if (bit_cnt_q == DATA_FIRST) begin
          shift_out_d = rd_valid_q ? rd_data_q : '1;
          underrun    = ~rd_valid_q;
          rd_wanted_d = 1'b0;
          rd_valid_d  = 1'b0;
        end else if (bit_cnt_q > DATA_FIRST) begin
          shift_out_d = shift_out_q << 1;
        end
      end
    end
  end

  // Wishbone master FSM
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    err_d   = underrun;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (req_rd) begin
          state_d = ST_RD;
          adr_d   = req_adr;
        end else if (req_wr) begin
          state_d = ST_WR;
          adr_d   = req_adr;
          dat_d   = req_dat;
        end
      end
      default: begin
        if (bus.wb_ack_i) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          tmo_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (req_rd || req_wr) begin
          err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q  <= '0;
      ss_n_sync_q <= '1;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      cmd_rd_q    <= 1'b0;
      cmd_adr_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_wanted_q <= 1'b0;
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      ss_n_sync_q <= ss_n_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      cmd_rd_q    <= cmd_rd_d;
      cmd_adr_q   <= cmd_adr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_wanted_q <= rd_wanted_d;
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      err_q       <= err_d;
    end
  end

  assign bus.wb_cyc_o  = (state_q != ST_IDLE);
  assign bus.wb_stb_o  = (state_q != ST_IDLE);
  assign bus.wb_we_o   = (state_q == ST_WR);
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.busy_o    = (state_q != ST_IDLE);
  assign bus.err_o     = err_q;
  assign bus.miso_o    = shift_out_q[WB_DATA_WIDTH-1];
  assign bus.miso_oe_o = ss_active;

endmodule

// File: tb/tb_spi2wb_bridge.sv
// Directed bench: an SPI host drives two bridges (ack timeout 16 and 64)
// while per-bridge Wishbone targets with selectable ack latency watch cycles.
module tb_spi2wb_bridge;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       sck  = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] rd_data = 8'h00;
  int         ack_mode  = 0;   // 0: zero-wait, 1: ack after ack_delay cycles, 2: never
  int         ack_delay = 0;
  int         sel       = 0;   // which bridge the host samples miso from
  int         n_checks  = 0;
  int         n_errors  = 0;

  spi2wb_bridge_if #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8)) bus0 ();
  spi2wb_bridge_if #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8)) bus1 ();

  spi2wb_bridge #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .ACK_TIMEOUT(16)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0)
  );

  spi2wb_bridge #(.WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .ACK_TIMEOUT(64)) u_dut64 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  logic       cyc_w [2];
  logic       stb_w [2];
  logic       we_w  [2];
  logic       err_w [2];
  logic       ack_w [2];
  logic [1:0] adr_w [2];
  logic [7:0] dat_w [2];
  int         wait_cnt [2];

  assign bus0.sck_i    = sck;
  assign bus0.ss_n_i   = ss_n;
  assign bus0.mosi_i   = mosi;
  assign bus0.wb_dat_i = rd_data;
  assign bus0.wb_ack_i = ack_w[0];
  assign bus1.sck_i    = sck;
  assign bus1.ss_n_i   = ss_n;
  assign bus1.mosi_i   = mosi;
  assign bus1.wb_dat_i = rd_data;
  assign bus1.wb_ack_i = ack_w[1];

  assign cyc_w[0] = bus0.wb_cyc_o;
  assign stb_w[0] = bus0.wb_stb_o;
  assign we_w[0]  = bus0.wb_we_o;
  assign err_w[0] = bus0.err_o;
  assign adr_w[0] = bus0.wb_adr_o;
  assign dat_w[0] = bus0.wb_dat_o;
  assign cyc_w[1] = bus1.wb_cyc_o;
  assign stb_w[1] = bus1.wb_stb_o;
  assign we_w[1]  = bus1.wb_we_o;
  assign err_w[1] = bus1.err_o;
  assign adr_w[1] = bus1.wb_adr_o;
  assign dat_w[1] = bus1.wb_dat_o;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      ack_w[k] = cyc_w[k] & stb_w[k] &
                 ((ack_mode == 0) || (ack_mode == 1 && wait_cnt[k] == ack_delay));
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      wait_cnt[k] <= cyc_w[k] ? wait_cnt[k] + 1 : 0;
    end
  end

  // Wishbone monitor: cycle starts, acks, run lengths, err pulses
  int         starts   [2];
  int         acks     [2];
  int         errs     [2];
  int         run      [2];
  int         last_run [2];
  logic       c_we     [2];
  logic [1:0] c_adr    [2];
  logic [7:0] c_dat    [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cyc_w[k]) begin
        if (run[k] == 0) begin
          starts[k]++;
          c_we[k]  = we_w[k];
          c_adr[k] = adr_w[k];
          c_dat[k] = dat_w[k];
        end
        run[k]++;
        if (stb_w[k] && ack_w[k]) acks[k]++;
      end else if (run[k] != 0) begin
        last_run[k] = run[k];
        run[k]      = 0;
      end
      if (err_w[k]) errs[k]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_select();
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_deselect();
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Shifts the first n bits of word (MSB first); rx collects miso for bits 8..15
  task automatic spi_shift(input logic [15:0] word, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = word[15-i];
      repeat (4) @(negedge clk);
      if (i >= 8) rx = {rx[6:0], (sel == 1) ? bus1.miso_o : bus0.miso_o};
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] data, output logic [7:0] rx);
    spi_select();
    check("miso_oe_in_frame", (sel == 1) ? bus1.miso_oe_o : bus0.miso_oe_o, 1);
    spi_shift({cmd, data}, 16, rx);
    spi_deselect();
    $display("frame cmd=0x%02h data=0x%02h miso=0x%02h", cmd, data, rx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int s_st, s_ack, s_err, guard;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus0.wb_cyc_o, bus0.wb_stb_o, bus0.wb_we_o, bus0.busy_o, bus0.err_o,
           bus0.miso_o, bus0.miso_oe_o, bus0.wb_adr_o, bus0.wb_dat_o}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write: cmd 0x02, data 0x5A, zero-wait ack
    sel = 0; ack_mode = 0;
    s_st = starts[0]; s_ack = acks[0]; s_err = errs[0];
    spi_frame(8'h02, 8'h5A, rx);
    repeat (10) @(negedge clk);
    check("wr_cycles", starts[0] - s_st, 1);
    check("wr_acks",   acks[0] - s_ack, 1);
    check("wr_we",     c_we[0], 1);
    check("wr_adr",    c_adr[0], 2);
    check("wr_dat",    c_dat[0], 8'h5A);
    check("wr_len",    last_run[0], 1);
    check("wr_err",    errs[0] - s_err, 0);
    check("wr_busy",   bus0.busy_o, 0);

    // Read: cmd 0x81, zero-wait ack with 0xC3
    rd_data = 8'hC3;
    s_st = starts[0]; s_err = errs[0];
    spi_frame(8'h81, 8'h00, rx);
    repeat (10) @(negedge clk);
    check("rd_miso",   rx, 8'hC3);
    check("rd_cycles", starts[0] - s_st, 1);
    check("rd_we",     c_we[0], 0);
    check("rd_adr",    c_adr[0], 1);
    check("rd_err",    errs[0] - s_err, 0);

    // Read underrun on the 64-cycle-timeout bridge: ack arrives 40 cycles late
    sel = 1; ack_mode = 1; ack_delay = 40; rd_data = 8'h3C;
    s_st = starts[1]; s_ack = acks[1]; s_err = errs[1];
    spi_frame(8'h80, 8'h00, rx);
    repeat (80) @(negedge clk);
    check("ur_miso",   rx, 8'hFF);
    check("ur_err",    errs[1] - s_err, 1);
    check("ur_cycles", starts[1] - s_st, 1);
    check("ur_acks",   acks[1] - s_ack, 1);
    check("ur_len",    last_run[1], 41);
    check("ur_adr",    c_adr[1], 0);

    // Timeout: write 0x11 to adr 3, never acked
    sel = 0; ack_mode = 2;
    s_st = starts[0]; s_ack = acks[0]; s_err = errs[0];
    spi_frame(8'h03, 8'h11, rx);
    repeat (80) @(negedge clk);
    check("to_cycles", starts[0] - s_st, 1);
    check("to_len",    last_run[0], 16);
    check("to_acks",   acks[0] - s_ack, 0);
    check("to_err",    errs[0] - s_err, 1);
    check("to_adr",    c_adr[0], 3);
    check("to_dat",    c_dat[0], 8'h11);
    check("to_busy",   bus0.busy_o, 0);

    // Abort: ss_n released after 5 data bits, then a complete write
    ack_mode = 0;
    s_st = starts[0];
    spi_select();
    spi_shift({8'h02, 8'hFF}, 13, rx);
    spi_deselect();
    $display("frame aborted after 13 bits");
    check("ab_no_cycle", starts[0] - s_st, 0);
    spi_frame(8'h01, 8'hA5, rx);
    repeat (10) @(negedge clk);
    check("ab_next_cycles", starts[0] - s_st, 1);
    check("ab_next_we",     c_we[0], 1);
    check("ab_next_adr",    c_adr[0], 1);
    check("ab_next_dat",    c_dat[0], 8'hA5);

    // Reset in the middle of an unacked read
    ack_mode = 2;
    s_err = errs[0];
    spi_select();
    spi_shift({8'h82, 8'h00}, 8, rx);
    guard = 0;
    while (!bus0.wb_cyc_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("rs_cyc_seen", bus0.wb_cyc_o, 1);
    rst = 1'b1;
    #1;
    check("rs_outputs",
          {bus0.wb_cyc_o, bus0.wb_stb_o, bus0.wb_we_o, bus0.busy_o, bus0.err_o,
           bus0.miso_o, bus0.miso_oe_o, bus0.wb_adr_o, bus0.wb_dat_o}, 0);
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    $display("reset applied during read");
    ack_mode = 0;
    s_st = starts[0];
    spi_frame(8'h00, 8'h3C, rx);
    repeat (10) @(negedge clk);
    check("rs_wr_cycles", starts[0] - s_st, 1);
    check("rs_wr_we",     c_we[0], 1);
    check("rs_wr_adr",    c_adr[0], 0);
    check("rs_wr_dat",    c_dat[0], 8'h3C);
    check("rs_err",       errs[0] - s_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
